rs_issue_reader: RTL and testbench

RS_ISSUE_READER -- requirements
Module: rs_issue_reader

---
 rtl/rs_issue_reader.sv | 154 +++++++++++++++
 tb/tb_rs_issue_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_reader.sv
// Reservation-station issue reader: pulls one entry from the RS FIFO head,
// waits on the CDB for missing operands, then hands it to the functional unit.
module rs_issue_reader #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [OP_W-1:0]   fifo_op,
  input  logic              fifo_src1_rdy,
  input  logic              fifo_src2_rdy,
  input  logic [TAG_W-1:0]  fifo_src1_tag,
  input  logic [TAG_W-1:0]  fifo_src2_tag,
  input  logic [DATA_W-1:0] fifo_src1_val,
  input  logic [DATA_W-1:0] fifo_src2_val,
  input  logic [TAG_W-1:0]  fifo_rd_tag,
  output logic              fifo_deq,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OP_W-1:0]   issue_op,
  output logic [DATA_W-1:0] issue_src1,
  output logic [DATA_W-1:0] issue_src2,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic              occupied
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_ISSUE
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                rdy1_q, rdy1_d;
  logic                rdy2_q, rdy2_d;
  logic [TAG_W-1:0]    tag1_q, tag1_d;
  logic [TAG_W-1:0]    tag2_q, tag2_d;
  logic [DATA_W-1:0]   val1_q, val1_d;
  logic [DATA_W-1:0]   val2_q, val2_d;
  logic [TAG_W-1:0]    rd_q, rd_d;

  logic load;
  logic hit1_in, hit2_in;
  logic hit1_h, hit2_h;

  // Load decision plus CDB snoop on both the incoming head and the held entry
  always_comb begin
    load = rst && !flush && !fifo_empty &&
           ((state_q == S_EMPTY) ||
            ((state_q == S_ISSUE) && issue_ready));

    hit1_in = cdb_valid && !fifo_src1_rdy &&
              (cdb_tag == fifo_src1_tag);
    hit2_in = cdb_valid && !fifo_src2_rdy &&
              (cdb_tag == fifo_src2_tag);
    hit1_h  = cdb_valid && !rdy1_q &&
              (cdb_tag == tag1_q);
    hit2_h  = cdb_valid && !rdy2_q &&
              (cdb_tag == tag2_q);
  end

  // Next-state and holding-register update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    rd_d    = rd_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else if (load) begin
      op_d   = fifo_op;
      tag1_d = fifo_src1_tag;
      tag2_d = fifo_src2_tag;
      rd_d   = fifo_rd_tag;
      rdy1_d = fifo_src1_rdy || hit1_in;
      rdy2_d = fifo_src2_rdy || hit2_in;
      val1_d = hit1_in ? cdb_data : fifo_src1_val;
      val2_d = hit2_in ? cdb_data : fifo_src2_val;
      state_d = (rdy1_d && rdy2_d) ? S_ISSUE : S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (hit1_h) begin
            rdy1_d = 1'b1;
            val1_d = cdb_data;
          end
          if (hit2_h) begin
            rdy2_d = 1'b1;
            val2_d = cdb_data;
          end
          if (rdy1_d && rdy2_d)
            state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (issue_ready)
            state_d = S_EMPTY;
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // State and holding registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      op_q    <= '0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      rd_q    <= rd_d;
    end
  end

  // Handshake outputs are suppressed in a reset or flush cycle
  always_comb begin
    fifo_deq     = load;
    issue_valid  = rst && !flush && (state_q == S_ISSUE);
    occupied     = rst && (state_q != S_EMPTY);
    issue_op     = op_q;
    issue_src1   = val1_q;
    issue_src2   = val2_q;
    issue_rd_tag = rd_q;
  end

endmodule

// File: tb/tb_rs_issue_reader.sv
// Bench for rs_issue_reader: cycle-level vector table for the corner cases,
// then a FIFO model with a payload scoreboard for streaming traffic.
module tb_rs_issue_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [15:0] fifo_op;
  logic        fifo_src1_rdy, fifo_src2_rdy;
  logic [5:0]  fifo_src1_tag, fifo_src2_tag;
  logic [31:0] fifo_src1_val, fifo_src2_val;
  logic [5:0]  fifo_rd_tag;
  logic        fifo_deq;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [15:0] issue_op;
  logic [31:0] issue_src1, issue_src2;
  logic [5:0]  issue_rd_tag;
  logic        occupied;

  rs_issue_reader dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_op(fifo_op),
    .fifo_src1_rdy(fifo_src1_rdy), .fifo_src2_rdy(fifo_src2_rdy),
    .fifo_src1_tag(fifo_src1_tag), .fifo_src2_tag(fifo_src2_tag),
    .fifo_src1_val(fifo_src1_val), .fifo_src2_val(fifo_src2_val),
    .fifo_rd_tag(fifo_rd_tag), .fifo_deq(fifo_deq),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_rd_tag(issue_rd_tag),
    .occupied(occupied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, fe; logic [15:0] op;
    logic r1; logic [5:0] t1; logic [31:0] v1;
    logic r2; logic [5:0] t2; logic [31:0] v2;
    logic [5:0] rd;
    logic cv; logic [5:0] ct; logic [31:0] cd;
    logic fl, ir;
    logic ed, ev, eo, ck;
    logic [15:0] eop; logic [31:0] e1, e2; logic [5:0] erd;
  } vec_t;

  typedef struct {
    logic [15:0] op;
    logic r1; logic [5:0] t1; logic [31:0] v1;
    logic r2; logic [5:0] t2; logic [31:0] v2;
    logic [5:0] rd;
  } ent_t;

  typedef struct {
    logic [15:0] op; logic [31:0] s1, s2; logic [5:0] rd;
  } exp_t;

  vec_t tv[$];
  ent_t fq[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   pop_pend = 0;
  bit   prev_hold = 0;
  exp_t prev_pay;

  function automatic logic [31:0] fdat(input logic [5:0] t);
    return 32'hCD00_0000 + {26'd0, t} * 32'h101;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic v(input bit r, input bit fe, input logic [15:0] op,
                   input bit r1, input logic [5:0] t1, input logic [31:0] v1,
                   input bit r2, input logic [5:0] t2, input logic [31:0] v2,
                   input logic [5:0] rd, input bit cv, input logic [5:0] ct,
                   input logic [31:0] cd, input bit fl, input bit ir,
                   input bit ed, input bit ev, input bit eo, input bit ck,
                   input logic [15:0] eop, input logic [31:0] e1,
                   input logic [31:0] e2, input logic [5:0] erd);
    vec_t x;
    x = '{r, fe, op, r1, t1, v1, r2, t2, v2, rd, cv, ct, cd, fl, ir,
          ed, ev, eo, ck, eop, e1, e2, erd};
    tv.push_back(x);
  endtask

  // Empty-FIFO vector
  task automatic ve(input bit r, input bit cv, input logic [5:0] ct,
                    input logic [31:0] cd, input bit fl, input bit ir,
                    input bit ed, input bit ev, input bit eo, input bit ck,
                    input logic [15:0] eop, input logic [31:0] e1,
                    input logic [31:0] e2, input logic [5:0] erd);
    v(r, 1, 16'hEEEE, 0, 6'd63, 32'hBAD0, 0, 6'd62, 32'hBAD1, 6'd61,
      cv, ct, cd, fl, ir, ed, ev, eo, ck, eop, e1, e2, erd);
  endtask

  task automatic run_vec(input vec_t x, input int idx);
    string s;
    @(negedge clk);
    rst = x.r; fifo_empty = x.fe; fifo_op = x.op;
    fifo_src1_rdy = x.r1; fifo_src1_tag = x.t1; fifo_src1_val = x.v1;
    fifo_src2_rdy = x.r2; fifo_src2_tag = x.t2; fifo_src2_val = x.v2;
    fifo_rd_tag = x.rd; cdb_valid = x.cv; cdb_tag = x.ct;
    cdb_data = x.cd; flush = x.fl; issue_ready = x.ir;
    #1;
    s = $sformatf("vec%0d", idx);
    chk({s, "_deq"}, {31'd0, fifo_deq}, {31'd0, x.ed});
    chk({s, "_valid"}, {31'd0, issue_valid}, {31'd0, x.ev});
    chk({s, "_occ"}, {31'd0, occupied}, {31'd0, x.eo});
    if (x.ck) begin
      chk({s, "_op"}, {16'd0, issue_op}, {16'd0, x.eop});
      chk({s, "_src1"}, issue_src1, x.e1);
      chk({s, "_src2"}, issue_src2, x.e2);
      chk({s, "_rd"}, {26'd0, issue_rd_tag}, {26'd0, x.erd});
    end
  endtask

  task automatic push_ent(input ent_t e);
    exp_t x;
    fq.push_back(e);
    x.op = e.op;
    x.s1 = e.r1 ? e.v1 : fdat(e.t1);
    x.s2 = e.r2 ? e.v2 : fdat(e.t2);
    x.rd = e.rd;
    exp_q.push_back(x);
  endtask

  // One cycle against the FIFO model; payload checked at each handshake
  task automatic mcycle(input bit ir, input bit cv, input logic [5:0] ct);
    exp_t x;
    @(negedge clk);
    if (pop_pend) fq.delete(0);
    rst = 1; flush = 0;
    fifo_empty = (fq.size() == 0);
    if (fq.size() != 0) begin
      fifo_op = fq[0].op;
      fifo_src1_rdy = fq[0].r1; fifo_src1_tag = fq[0].t1;
      fifo_src1_val = fq[0].v1;
      fifo_src2_rdy = fq[0].r2; fifo_src2_tag = fq[0].t2;
      fifo_src2_val = fq[0].v2;
      fifo_rd_tag = fq[0].rd;
    end else begin
      fifo_op = 16'hEEEE; fifo_src1_rdy = 1; fifo_src2_rdy = 1;
    end
    issue_ready = ir; cdb_valid = cv; cdb_tag = ct; cdb_data = fdat(ct);
    #1;
    pop_pend = fifo_deq;
    if (prev_hold) begin
      chk("hold_valid", {31'd0, issue_valid}, 32'd1);
      chk("hold_op", {16'd0, issue_op}, {16'd0, prev_pay.op});
      chk("hold_src1", issue_src1, prev_pay.s1);
      chk("hold_src2", issue_src2, prev_pay.s2);
    end
    prev_hold = issue_valid && !issue_ready;
    prev_pay = '{issue_op, issue_src1, issue_src2, issue_rd_tag};
    if (issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        chk("sb_op", {16'd0, issue_op}, {16'd0, x.op});
        chk("sb_src1", issue_src1, x.s1);
        chk("sb_src2", issue_src2, x.s2);
        chk("sb_rd", {26'd0, issue_rd_tag}, {26'd0, x.rd});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    int   cyc;
    rst = 0; fifo_empty = 1; fifo_op = 0;
    fifo_src1_rdy = 0; fifo_src2_rdy = 0;
    fifo_src1_tag = 0; fifo_src2_tag = 0;
    fifo_src1_val = 0; fifo_src2_val = 0; fifo_rd_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    flush = 0; issue_ready = 0;

    // reset with a non-empty head: nothing may be dequeued
    for (int i = 0; i < 2; i++)
      v(0, 0, 16'h9999, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1,
        0, 0, 0, 0, 0, 0, 0, 0);
    // idle after reset, FIFO empty
    for (int i = 0; i < 10; i++)
      ve(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // ready entry: deq now, issue next cycle
    v(1, 0, 16'h1234, 1, 1, 5, 1, 2, 7, 3, 0, 0, 0, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h1234, 5, 7, 3);
    ve(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // src1 waits for tag 9 broadcast in cycle 3
    v(1, 0, 16'h0040, 0, 9, 32'hDEAD, 1, 4, 2, 4, 0, 0, 0, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 1, 8, 32'h88, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 1, 9, 32'hAA, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 1, 9, 32'hBB, 0, 1, 0, 1, 1, 1, 16'h0040, 32'hAA, 2, 4);
    // snoop during the load cycle
    v(1, 0, 16'h0041, 0, 9, 0, 1, 4, 3, 5, 1, 9, 32'hCC, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0041, 32'hCC, 3, 5);
    // both operands resolved by one broadcast
    v(1, 0, 16'h0042, 0, 12, 0, 0, 12, 0, 6, 0, 0, 0, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 1, 12, 32'h55, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0042, 32'h55, 32'h55, 6);
    // backpressure: payload held, no deq, CDB noise ignored
    v(1, 0, 16'h0050, 1, 21, 32'h11, 1, 22, 32'h22, 7, 0, 0, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      v(1, 0, 16'h0051, 1, 1, 1, 1, 2, 2, 8, 1, 6'(20 + i), 32'hF0, 0, 0,
        0, 1, 1, 1, 16'h0050, 32'h11, 32'h22, 7);
    v(1, 0, 16'h0051, 1, 1, 1, 1, 2, 2, 8, 0, 0, 0, 0, 1,
      1, 1, 1, 1, 16'h0050, 32'h11, 32'h22, 7);
    ve(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0051, 1, 2, 8);
    // flush while waiting
    v(1, 0, 16'h0060, 0, 30, 0, 1, 1, 1, 9, 0, 0, 0, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 16'h0061, 1, 1, 1, 1, 1, 1, 9, 1, 30, 32'h77, 1, 1,
      0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset while issuing with issue_ready high
    v(1, 0, 16'h0070, 1, 1, 1, 1, 1, 1, 10, 0, 0, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 16'h0071, 1, 1, 1, 1, 1, 1, 10, 0, 0, 0, 0, 1,
      0, 0, 0, 0, 0, 0, 0, 0);
    // load in the first cycle after reset release
    v(1, 0, 16'h0072, 1, 1, 3, 1, 1, 4, 11, 0, 0, 0, 0, 1,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0072, 3, 4, 11);
    ve(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush while issuing
    v(1, 0, 16'h0080, 1, 1, 1, 1, 1, 1, 12, 0, 0, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    ve(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tv[i]) run_vec(tv[i], i);

    // back-to-back throughput with four ready entries
    for (int i = 0; i < 4; i++) begin
      e = '{16'h00A0 + 16'(i), 1, 6'd1, 32'h100 + i,
            1, 6'd2, 32'h200 + i, 6'(i)};
      push_ent(e);
    end
    for (int c = 0; c < 6; c++) begin
      mcycle(1, 0, 0);
      chk($sformatf("thr_deq%0d", c), {31'd0, fifo_deq},
          (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("thr_valid%0d", c), {31'd0, issue_valid},
          (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
    end

    // random stream: mixed readiness, CDB sweep, random backpressure
    for (int i = 0; i < 40; i++) begin
      e.op = 16'h0B00 + 16'(i);
      e.r1 = 1'($urandom_range(0, 1)); e.t1 = 6'($urandom_range(0, 15));
      e.v1 = $urandom;
      e.r2 = 1'($urandom_range(0, 1)); e.t2 = 6'($urandom_range(0, 15));
      e.v2 = $urandom;
      e.rd = 6'($urandom_range(0, 63));
      push_ent(e);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      mcycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             6'(cyc % 16));
      cyc++;
    end
    chk("stream_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
